// File: rtl/des_core.sv
// des_core: single-cycle DES engine (FIPS 46-3). Key/mode, data and result
// registers surround a fully unrolled 16-round combinational datapath, so a
// data strobe at one edge yields its result at the next edge.
module des_core (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        keyin,
  input  logic [63:0] k,
  input  logic        datin,
  input  logic [63:0] ptxt,
  output logic [63:0] etxt,
  input  logic        f
);

  // Permutation tables hold FIPS bit numbers (1 = MSB of the source vector).
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_T [0:63] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // PC1 skips bits 8, 16, ..., 64, which is what makes the key parity-blind.
  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied to C and D before each subkey.
  localparam int SHIFT_T [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // S-boxes stored row-major: entry index = {row[1:0], col[3:0]}.
  localparam logic [3:0] SBOX_T [0:7][0:63] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] f_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] f_rol28(input logic [27:0] x, input int n);
    if (n == 2) return {x[25:0], x[27:26]};
    return {x[26:0], x[27]};
  endfunction

  // Outer bits pick the S-box row, inner four bits pick the column.
  function automatic logic [3:0] f_sbox(input int n, input logic [5:0] b);
    return SBOX_T[n][{b[5], b[0], b[4:1]}];
  endfunction

  function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] x;
    logic [31:0] s;
    x = f_e(r) ^ sk;
    s = '0;
    for (int n = 0; n < 8; n++) s[31-4*n -: 4] = f_sbox(n, x[47-6*n -: 6]);
    return f_p(s);
  endfunction

  logic [63:0] r_key;
  logic        r_mode;
  logic [63:0] r_data;
  logic        r_pend;
  logic [63:0] r_etxt;

  logic [55:0] w_pc1;
  logic [47:0] w_ks [1:16];
  logic [63:0] w_result;

  assign w_pc1 = f_pc1(r_key);
  assign etxt  = r_etxt;

  // Subkey schedule: cumulative C/D rotations, each compressed by PC2.
  always_comb begin
    logic [27:0] v_c;
    logic [27:0] v_d;
    w_ks = '{default: '0};
    v_c  = w_pc1[55:28];
    v_d  = w_pc1[27:0];
    for (int r = 1; r <= 16; r++) begin
      v_c     = f_rol28(v_c, SHIFT_T[r]);
      v_d     = f_rol28(v_d, SHIFT_T[r]);
      w_ks[r] = f_pc2({v_c, v_d});
    end
  end

  // Sixteen unrolled Feistel rounds; decrypt simply walks the subkeys backwards.
  always_comb begin
    logic [63:0] v_lr;
    logic [47:0] v_sk;
    v_lr = f_ip(r_data);
    v_sk = '0;
    for (int r = 1; r <= 16; r++) begin
      v_sk = r_mode ? w_ks[r] : w_ks[17-r];
      v_lr = {v_lr[31:0], v_lr[63:32] ^ f_feistel(v_lr[31:0], v_sk)};
    end
    // The last round's swap is undone before the final permutation.
    w_result = f_fp({v_lr[31:0], v_lr[63:32]});
  end

  // Key and direction register, loaded by the key strobe.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_mode <= 1'b0;
    end else if (keyin) begin
      r_key  <= k;
      r_mode <= f;
    end
  end

  // Data register; pend marks that the next edge must capture a result.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_data <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= datin;
      if (datin) r_data <= ptxt;
    end
  end

  // Result register, updated only on the edge after a data strobe.
  always_ff @(posedge ck) begin
    if (!rst_n) r_etxt <= '0;
    else if (r_pend) r_etxt <= w_result;
  end

endmodule

// File: tb/tb_des_core.sv
// tb_des_core: directed bench for des_core. Expected blocks are queued when a
// data strobe is driven and popped on the edge where the result is captured.
module tb_des_core;

  logic        ck;
  logic        rst_n;
  logic        keyin;
  logic [63:0] k;
  logic        datin;
  logic [63:0] ptxt;
  logic [63:0] etxt;
  logic        f;

  int n_tests;
  int n_fail;
  bit tb_pend;

  typedef struct {
    string       tag;
    logic [63:0] exp;
    bit          chk;
  } sb_t;
  sb_t sb[$];

  localparam logic [63:0] K_STD  = 64'h133457799BBCDFF1;
  localparam logic [63:0] P_STD  = 64'h0123456789ABCDEF;
  localparam logic [63:0] C_STD  = 64'h85E813540F0AB405;
  localparam logic [63:0] C_ZERO = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] K_RT   = 64'hDAB783857DCED3C8;

  des_core dut (
    .ck    (ck),
    .rst_n (rst_n),
    .keyin (keyin),
    .k     (k),
    .datin (datin),
    .ptxt  (ptxt),
    .etxt  (etxt),
    .f     (f)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] exp, input bit chk);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    e.chk = chk;
    sb.push_back(e);
  endtask

  // One clock: a capture happens at this edge when the previous edge loaded
  // data and reset is not asserted now.
  task automatic tick();
    bit   cap;
    bit   nxt;
    sb_t  e;
    cap = tb_pend && rst_n;
    nxt = rst_n && datin;
    @(posedge ck);
    #1;
    tb_pend = nxt;
    if (cap) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed etxt %h expected a queued entry", etxt);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk) check(e.tag, etxt, e.exp);
      end
    end
  endtask

  task automatic load_key(input logic [63:0] key, input logic mode);
    keyin = 1'b1;
    k     = key;
    f     = mode;
    tick();
    keyin = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [63:0] p, input logic [63:0] exp);
    ptxt  = p;
    datin = 1'b1;
    push(tag, exp, 1'b1);
    tick();
    datin = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tb_pend = 1'b0;
    rst_n   = 1'b0;
    keyin   = 1'b0;
    datin   = 1'b0;
    k       = '0;
    f       = 1'b0;
    ptxt    = '0;
    tick();
    tick();
    check("reset_etxt", etxt, 64'h0);
    rst_n = 1'b1;
    tick();

    // Known answer, encrypt, plus key schedule spot checks.
    load_key(K_STD, 1'b1);
    check("pc1", {8'h00, dut.w_pc1}, 64'h00F0CCAAF556678F);
    check("ks01", {16'h0, dut.w_ks[1]}, 64'h00001B02EFFC7072);
    check("ks16", {16'h0, dut.w_ks[16]}, 64'h0000CB3D8B0E17F5);
    run_block("kat_enc", P_STD, C_STD);

    // Key activity and ptxt changes without a data strobe leave etxt alone.
    load_key(64'h0, 1'b0);
    ptxt = 64'hFFFF_0000_AAAA_5555;
    tick();
    tick();
    check("hold_etxt", etxt, C_STD);

    // Known answer, decrypt.
    load_key(K_STD, 1'b0);
    run_block("kat_dec", C_STD, P_STD);

    // Zero vector and parity-bit independence.
    load_key(64'h0, 1'b1);
    run_block("zero_enc", 64'h0, C_ZERO);
    load_key(64'h0101010101010101, 1'b1);
    run_block("parity_enc", 64'h0, C_ZERO);

    // Key and data strobes on the same edge: the new key applies.
    keyin = 1'b1;
    k     = K_STD;
    f     = 1'b1;
    ptxt  = P_STD;
    datin = 1'b1;
    push("same_edge_key", C_STD, 1'b1);
    tick();
    keyin = 1'b0;
    datin = 1'b0;
    tick();

    // Key load one edge after the data strobe: the old key applies.
    load_key(64'h0, 1'b1);
    ptxt  = 64'h0;
    datin = 1'b1;
    push("late_key_old", C_ZERO, 1'b1);
    tick();
    datin = 1'b0;
    keyin = 1'b1;
    k     = K_STD;
    f     = 1'b1;
    tick();
    keyin = 1'b0;

    // Back-to-back strobes; key 0 is weak so encrypting twice restores the block.
    load_key(64'h0, 1'b1);
    ptxt  = 64'h0;
    datin = 1'b1;
    push("b2b_first", C_ZERO, 1'b1);
    tick();
    ptxt = C_ZERO;
    push("b2b_second", 64'h0, 1'b1);
    tick();
    datin = 1'b0;
    tick();
    check("b2b_last_holds", etxt, 64'h0);

    // Round trips: encrypt, then decrypt the observed ciphertext.
    for (int i = 0; i < 5; i++) begin
      logic [63:0] p;
      logic [63:0] c;
      p = (i == 0) ? 64'h2ECEA62A2ECEA62A : {$urandom, $urandom};
      load_key(K_RT, 1'b1);
      ptxt  = p;
      datin = 1'b1;
      push("rt_enc", 64'h0, 1'b0);
      tick();
      datin = 1'b0;
      tick();
      c     = etxt;
      keyin = 1'b1;
      k     = K_RT;
      f     = 1'b0;
      ptxt  = c;
      datin = 1'b1;
      push($sformatf("rt_dec%0d", i), p, 1'b1);
      tick();
      keyin = 1'b0;
      datin = 1'b0;
      tick();
    end

    // Reset while a capture is pending: nothing is captured, etxt clears.
    load_key(K_STD, 1'b1);
    ptxt  = P_STD;
    datin = 1'b1;
    tick();
    datin = 1'b0;
    rst_n = 1'b0;
    tick();
    check("reset_pend_etxt", etxt, 64'h0);
    rst_n = 1'b1;
    tick();
    check("reset_no_capture", etxt, 64'h0);

    // After reset the key is 0 in decrypt mode.
    ptxt  = 64'h0;
    datin = 1'b1;
    push("post_reset_dec0", C_ZERO, 1'b1);
    tick();
    ptxt = C_ZERO;
    push("post_reset_dec1", 64'h0, 1'b1);
    tick();
    datin = 1'b0;
    tick();

    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
